// File: rtl/power_seq_ctrl_if.sv
// Operand/result bundle for the sequential power unit.
// master: keypad/operand side; slave: power_seq_ctrl.
interface power_seq_ctrl_if #(
  parameter int unsigned BASE_W = 4,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned RES_W  = 16
);
  logic              start;
  logic [BASE_W-1:0] base;
  logic [EXP_W-1:0]  exp;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  result;
  logic              overflow;

  modport master (
    output start, base, exp,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, base, exp,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/power_seq_ctrl.sv
// Sequential power unit: result = base^exp via one multiply per clock.
// IDLE/MUL/DONE FSM with start/busy/done handshake; all outputs registered.
// Optional build macro POWER_SATURATE_EN: clamp the accumulator to all ones
// once any multiply overflows (default: keep the truncated product).
module power_seq_ctrl #(
  parameter int unsigned BASE_W = 4,
  parameter int unsigned EXP_W  = 3,
  parameter int unsigned RES_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  power_seq_ctrl_if.slave    bus
);

  localparam int unsigned P_W = RES_W + BASE_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [RES_W-1:0]  acc_q,      acc_d;
  logic [EXP_W-1:0]  cnt_q,      cnt_d;
  logic [BASE_W-1:0] base_q,     base_d;
  logic              ovf_q,      ovf_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic [RES_W-1:0]  result_q,   result_d;
  logic              overflow_q, overflow_d;

  logic [P_W-1:0]    prod;
  logic              prod_hi;

  // Shared multiplier: full-width product and its overflow indication
  always_comb begin
    prod    = P_W'(acc_q) * P_W'(base_q);
    prod_hi = |prod[P_W-1:RES_W];
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          cnt_d   = bus.exp;
          acc_d   = RES_W'(1);
          ovf_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q != EXP_W'(0)) begin
          cnt_d = cnt_q - EXP_W'(1);
          ovf_d = ovf_q | prod_hi;
`ifdef POWER_SATURATE_EN
          acc_d = (ovf_q | prod_hi) ? {RES_W{1'b1}} : prod[RES_W-1:0];
`else
          acc_d = prod[RES_W-1:0];
`endif
        end else begin
          result_d   = acc_q;
          overflow_d = ovf_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      base_q     <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule
